// File: rtl/cs_resolve_89.sv
// Carry-save to canonical residue resolver: a chunk-serial carry-propagate add,
// then a chunk-serial trial subtraction of P and 2P, then pick the smallest non-negative result.
module cs_resolve_89 #(
  parameter logic [88:0] P     = 89'h19f393cffffffffffffffff,
  parameter int          CHUNK = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [88:0] c_i,
  input  logic [88:0] s_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [88:0] out_data,
  output logic [1:0]  out_nsub
);
  localparam int W   = 90;
  localparam int NCH = W / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [W-1:0] P1 = {1'b0, P};
  localparam logic [W-1:0] P2 = {P, 1'b0};

  typedef enum logic [1:0] {IDLE, ADD, SUB, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [W-1:0]     c_q, c_d, s_q, s_d, sum_q, sum_d;
  logic             cy_q, cy_d, b1_q, b1_d, b2_q, b2_d;
  logic             out_valid_q, out_valid_d;
  logic [88:0]      out_data_q, out_data_d;
  logic [1:0]       out_nsub_q, out_nsub_d;
  logic [CHUNK-1:0] add_r, sub1_r, sub2_r;
  logic             add_co, sub1_bo, sub2_bo, last;

  assign last = (k_q == KW'(NCH - 1));

  // c/s registers are reused: in ADD they shift the operands out, in SUB they
  // shift P/2P out at the bottom while d1/d2 chunks shift in at the top.
  assign {add_co, add_r}   = {1'b0, c_q[CHUNK-1:0]} + {1'b0, s_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
  assign {sub1_bo, sub1_r} = {1'b0, sum_q[CHUNK-1:0]} - {1'b0, c_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, b1_q};
  assign {sub2_bo, sub2_r} = {1'b0, sum_q[CHUNK-1:0]} - {1'b0, s_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, b2_q};

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    c_d         = c_q;
    s_d         = s_q;
    sum_d       = sum_q;
    cy_d        = cy_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_nsub_d  = out_nsub_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          c_d     = {1'b0, c_i};
          s_d     = {1'b0, s_i};
          cy_d    = 1'b0;
          k_d     = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d = (sum_q >> CHUNK) | (W'(add_r) << (W - CHUNK));
        c_d   = c_q >> CHUNK;
        s_d   = s_q >> CHUNK;
        cy_d  = add_co;
        k_d   = k_q + KW'(1);
        if (last) begin
          c_d     = P1;
          s_d     = P2;
          b1_d    = 1'b0;
          b2_d    = 1'b0;
          k_d     = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        // sum rotates so it is back in place after the last chunk
        sum_d = (sum_q >> CHUNK) | (sum_q << (W - CHUNK));
        c_d   = (c_q >> CHUNK) | (W'(sub1_r) << (W - CHUNK));
        s_d   = (s_q >> CHUNK) | (W'(sub2_r) << (W - CHUNK));
        b1_d  = sub1_bo;
        b2_d  = sub2_bo;
        k_d   = k_q + KW'(1);
        if (last) begin
          k_d         = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (!sub2_bo) begin
            out_data_d = s_d[88:0];
            out_nsub_d = 2'd2;
          end else if (!sub1_bo) begin
            out_data_d = c_d[88:0];
            out_nsub_d = 2'd1;
          end else begin
            out_data_d = sum_d[88:0];
            out_nsub_d = 2'd0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      c_q         <= '0;
      s_q         <= '0;
      sum_q       <= '0;
      cy_q        <= 1'b0;
      b1_q        <= 1'b0;
      b2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nsub_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      s_q         <= s_d;
      sum_q       <= sum_d;
      cy_q        <= cy_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nsub_q  <= out_nsub_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_nsub  = out_nsub_q;
endmodule

// File: tb/tb_cs_resolve_89.sv
// Directed and randomized bench for cs_resolve_89: latency, reduction results,
// back-pressure, mid-operation reset and a streaming run against a reference model.
module tb_cs_resolve_89;
  localparam logic [88:0] PM = 89'h19f393cffffffffffffffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [88:0] c_i, s_i, out_data;
  logic [1:0]  out_nsub;
  int          total = 0;
  int          bad = 0;

  cs_resolve_89 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c_i(c_i), .s_i(s_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nsub(out_nsub)
  );

  always #5 clk = ~clk;

  function automatic void ref_mod(input logic [88:0] c, input logic [88:0] s,
                                  output logic [88:0] r, output logic [1:0] n);
    logic [89:0] sum;
    sum = {1'b0, c} + {1'b0, s};
    if (sum >= {PM, 1'b0}) begin
      sum = sum - {PM, 1'b0};
      n = 2'd2;
    end else if (sum >= {1'b0, PM}) begin
      sum = sum - {1'b0, PM};
      n = 2'd1;
    end else begin
      n = 2'd0;
    end
    r = sum[88:0];
  endfunction

  function automatic logic [88:0] rnd89();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[88:0];
  endfunction

  task automatic send(input logic [88:0] c, input logic [88:0] s);
    c_i = c; s_i = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; c_i = '1; s_i = '1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; c_i = '0; s_i = '0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 89'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (out_nsub !== 2'd0) begin bad++; $display("FAIL reset_nsub got=%0d exp=0", out_nsub); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_simple();
    int lat;
    send(89'd5, 89'd7);
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL simple_latency got=%0d exp=6", lat); end
    total++; if (out_data !== 89'd12) begin bad++; $display("FAIL simple_data got=%h exp=c", out_data); end
    total++; if (out_nsub !== 2'd0) begin bad++; $display("FAIL simple_nsub got=%0d exp=0", out_nsub); end
    pop();
  endtask

  task automatic test_modulus();
    int lat;
    send(PM - 89'd1, 89'd1);
    wait_valid(lat);
    total++; if (out_data !== 89'd0) begin bad++; $display("FAIL mod1_data got=%h exp=0", out_data); end
    total++; if (out_nsub !== 2'd1) begin bad++; $display("FAIL mod1_nsub got=%0d exp=1", out_nsub); end
    pop();
    send(PM, PM);
    wait_valid(lat);
    total++; if (out_data !== 89'd0) begin bad++; $display("FAIL mod2_data got=%h exp=0", out_data); end
    total++; if (out_nsub !== 2'd2) begin bad++; $display("FAIL mod2_nsub got=%0d exp=2", out_nsub); end
    pop();
  endtask

  task automatic test_max();
    int lat;
    send('1, '1);
    wait_valid(lat);
    total++; if (out_data !== 89'hc18d860000000000000000) begin bad++; $display("FAIL max_data got=%h exp=c18d860000000000000000", out_data); end
    total++; if (out_nsub !== 2'd2) begin bad++; $display("FAIL max_nsub got=%0d exp=2", out_nsub); end
    pop();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [88:0] exp_d;
    exp_d = 89'h123456789abcdea;
    send(89'h123456789abcdef, PM - 89'd5);
    wait_valid(lat);
    // keep offering junk; nothing may be accepted while a result is pending
    in_valid = 1'b1; c_i = 89'd1; s_i = 89'd2;
    repeat (10) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
      total++; if (out_data !== exp_d) begin bad++; $display("FAIL bp_data got=%h exp=%h", out_data, exp_d); end
      total++; if (out_nsub !== 2'd1) begin bad++; $display("FAIL bp_nsub got=%0d exp=1", out_nsub); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
      @(posedge clk); #1;
    end
    pop();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_after_valid got=%b exp=0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    send('1, 89'h5555);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 89'd0) begin bad++; $display("FAIL rmid_data got=%h exp=0", out_data); end
    total++; if (out_nsub !== 2'd0) begin bad++; $display("FAIL rmid_nsub got=%0d exp=0", out_nsub); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_spurious got=%b exp=0", out_valid); end
    end
    send(89'd3, 89'd4);
    wait_valid(lat);
    total++; if (lat != 6) begin bad++; $display("FAIL rmid_latency got=%0d exp=6", lat); end
    total++; if (out_data !== 89'd7) begin bad++; $display("FAIL rmid_result got=%h exp=7", out_data); end
    pop();
  endtask

  task automatic test_random();
    int lat;
    int got = 0;
    logic [88:0] c, s, er;
    logic [1:0] en;
    for (int i = 0; i < 1500; i++) begin
      c = rnd89(); s = rnd89();
      case ($urandom_range(0, 3))
        0: begin c = PM - 89'($urandom_range(0, 20)); s = 89'($urandom_range(0, 40)); end
        1: begin c = '1; s = '1 - 89'($urandom_range(0, 1000)); end
        default: ;
      endcase
      ref_mod(c, s, er, en);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready i=%0d got=%b exp=1", i, in_ready); end
      send(c, s);
      wait_valid(lat);
      if (out_valid) got++;
      total++; if (lat != 6) begin bad++; $display("FAIL rnd_latency i=%0d got=%0d exp=6", i, lat); end
      total++; if (out_data !== er) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, out_data, er); end
      total++; if (out_nsub !== en) begin bad++; $display("FAIL rnd_nsub i=%0d got=%0d exp=%0d", i, out_nsub, en); end
      total++; if (!(out_data < PM)) begin bad++; $display("FAIL rnd_range i=%0d got=%h exp<%h", i, out_data, PM); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      pop();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rnd_dup i=%0d got=%b exp=0", i, out_valid); end
    end
    total++; if (got != 1500) begin bad++; $display("FAIL rnd_count got=%0d exp=1500", got); end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_modulus();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
